// File: rtl/riscv_instr_port_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_instr_port_arbiter
//
// Shares one instruction-memory port (req/gnt/rvalid) between two fetch
// requesters: port 0 (prefetch buffer) and port 1 (debug / program-buffer
// fetch). Each address phase is arbitrated. The winner is locked until the
// memory grants it. The owner of every granted transaction is recorded in an
// in-order ID FIFO, and each rvalid is steered back to that owner.
//
// Parameters:
//   MAX_OUTSTANDING  granted-but-unanswered transactions allowed (1..4)
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   m0_req_i/m0_addr_i             port 0 request and address
//   m0_gnt_o/m0_rvalid_o           port 0 grant and response valid
//   m1_*                           same as port 0, for port 1
//   rdata_o                        response data, broadcast to both ports
//   instr_req_o/instr_addr_o       memory request and address
//   instr_gnt_i                    memory grant
//   instr_rdata_i/instr_rvalid_i   memory response data and valid
//   busy_o                         transactions outstanding or request pending
//
// Build option:
//   INSTR_ARB_ROUND_ROBIN_EN  when defined, an unlocked conflict goes to the
//                             port that was not granted last. Otherwise
//                             port 0 always wins.
// -----------------------------------------------------------------------------
module riscv_instr_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] rdata_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_rvalid_i,
    output logic        busy_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_e;

    lock_e                      lock_q, lock_d;
    logic                       owner_q, owner_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;

    logic winner;
    logic win_req;
    logic can_issue;
    logic push;
    logic pop;
    logic head_id;

`ifdef INSTR_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Winner selection: a locked owner keeps the port until it is granted.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so
        // that no path leaves it unassigned and infers a latch.
        winner = 1'b0;
        if (lock_q == LOCKED) begin
            winner = owner_q;
        end else if (m0_req_i && m1_req_i) begin
`ifdef INSTR_ARB_ROUND_ROBIN_EN
            winner = ~last_q;
`else
            winner = 1'b0;
`endif
        end else begin
            // Only port 1 requesting selects it; otherwise port 0 (which also
            // makes the idle address m0_addr_i).
            winner = m1_req_i;
        end
    end

    // A same-cycle response frees a slot, so a full FIFO can still issue.
    assign can_issue    = (count_q < CNT_MAX) || instr_rvalid_i;
    assign win_req      = winner ? m1_req_i : m0_req_i;
    assign instr_req_o  = win_req && can_issue;
    assign instr_addr_o = winner ? m1_addr_i : m0_addr_i;

    assign push    = instr_req_o && instr_gnt_i;
    // Responses with nothing outstanding are dropped entirely.
    assign pop     = instr_rvalid_i && (count_q != '0);
    assign head_id = id_q[rd_ptr_q];

    assign m0_gnt_o    = push && !winner;
    assign m1_gnt_o    = push &&  winner;
    assign m0_rvalid_o = pop  && !head_id;
    assign m1_rvalid_o = pop  &&  head_id;
    assign rdata_o     = instr_rdata_i;
    assign busy_o      = (count_q != '0) || instr_req_o;

    // Next-state: lock, ID FIFO and outstanding count.
    always_comb begin
        lock_d   = lock_q;
        owner_d  = owner_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        id_d     = id_q;

        unique case (lock_q)
            UNLOCKED: begin
                if (instr_req_o && !instr_gnt_i) begin
                    lock_d  = LOCKED;
                    owner_d = winner;
                end
            end
            LOCKED: begin
                // A dropped request keeps the lock; only a grant releases it.
                if (instr_req_o && instr_gnt_i) begin
                    lock_d = UNLOCKED;
                end
            end
            default: lock_d = UNLOCKED;
        endcase

        if (push) begin
            id_d[wr_ptr_q] = winner;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of the others.
            lock_q   <= UNLOCKED;
            owner_q  <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            // NOTE: the ID storage is only a few flops and is reset, so the
            // head read is never X even though count_q already gates its use.
            id_q     <= '0;
        end else begin
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            id_q     <= id_d;
        end
    end

`ifdef INSTR_ARB_ROUND_ROBIN_EN
    always_comb begin
        last_d = last_q;
        if (push) begin
            last_d = winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // A response with nothing outstanding is a memory protocol violation.
    // It is tolerated in hardware and only reported here.
    stray_rvalid_a : assert property (
        @(posedge clk) disable iff (!rst_n) instr_rvalid_i |-> (count_q != '0)
    ) else $warning("stray instr_rvalid_i with no outstanding request ignored");

endmodule

// File: tb/tb_riscv_instr_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for riscv_instr_port_arbiter (MAX_OUTSTANDING = 2).
// A directed vector table, hand-written sequences for conflict and
// mid-transaction reset, and a randomized phase against a queue-based model.
// -----------------------------------------------------------------------------
module tb_riscv_instr_port_arbiter;

    localparam int MAX_OUT = 2;

    logic        clk;
    logic        rst_n;
    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] rdata_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic [31:0] instr_rdata_i;
    logic        instr_rvalid_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: locked port (-1 = none), owner queue, last winner.
    int m_lock;
    int m_q[$];
    int m_last;

    riscv_instr_port_arbiter #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0_req_i       (m0_req_i),
        .m0_addr_i      (m0_addr_i),
        .m0_gnt_o       (m0_gnt_o),
        .m0_rvalid_o    (m0_rvalid_o),
        .m1_req_i       (m1_req_i),
        .m1_addr_i      (m1_addr_i),
        .m1_gnt_o       (m1_gnt_o),
        .m1_rvalid_o    (m1_rvalid_o),
        .rdata_o        (rdata_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_rvalid_i (instr_rvalid_i),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m0r;
        logic [31:0] m0a;
        logic        m1r;
        logic [31:0] m1a;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_g0;
        logic        e_g1;
        logic        e_v0;
        logic        e_v1;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic m0r, input logic [31:0] m0a, input logic m1r, input logic [31:0] m1a,
        input logic gnt, input logic rv, input logic [31:0] rd,
        input logic er, input logic [31:0] ea, input logic eg0, input logic eg1,
        input logic ev0, input logic ev1, input logic eb);
        vec_t v;
        v.m0r = m0r; v.m0a = m0a; v.m1r = m1r; v.m1a = m1a;
        v.gnt = gnt; v.rv = rv; v.rd = rd;
        v.e_req = er; v.e_addr = ea; v.e_g0 = eg0; v.e_g1 = eg1;
        v.e_v0 = ev0; v.e_v1 = ev1; v.e_busy = eb;
        return v;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic er, input logic [31:0] ea,
                             input logic eg0, input logic eg1, input logic ev0,
                             input logic ev1, input logic eb);
        check_bit ({tag, ".req"},    instr_req_o,  er);
        check_word({tag, ".addr"},   instr_addr_o, ea);
        check_bit ({tag, ".gnt0"},   m0_gnt_o,     eg0);
        check_bit ({tag, ".gnt1"},   m1_gnt_o,     eg1);
        check_bit ({tag, ".rvalid0"}, m0_rvalid_o, ev0);
        check_bit ({tag, ".rvalid1"}, m1_rvalid_o, ev1);
        check_bit ({tag, ".busy"},   busy_o,       eb);
        check_word({tag, ".rdata"},  rdata_o,      instr_rdata_i);
    endtask

    task automatic drive(input logic m0r, input logic [31:0] m0a, input logic m1r,
                         input logic [31:0] m1a, input logic gnt, input logic rv,
                         input logic [31:0] rd);
        m0_req_i = m0r; m0_addr_i = m0a;
        m1_req_i = m1r; m1_addr_i = m1a;
        instr_gnt_i = gnt; instr_rvalid_i = rv; instr_rdata_i = rd;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 3 units later, well before the next edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_lock = -1;
        m_q.delete();
        m_last = 0;
    endtask

    // Expected conflict winner on the i-th consecutive conflict after reset.
    function automatic int conflict_winner(input int i);
`ifdef INSTR_ARB_ROUND_ROBIN_EN
        return (i % 2 == 0) ? 1 : 0;
`else
        return (i < 0) ? 1 : 0;
`endif
    endfunction

    function automatic int model_winner();
        if (m_lock >= 0) return m_lock;
        if (m0_req_i && m1_req_i) begin
`ifdef INSTR_ARB_ROUND_ROBIN_EN
            return 1 - m_last;
`else
            return 0;
`endif
        end
        return m1_req_i ? 1 : 0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        check_all("reset", 0, 32'h0, 0, 0, 0, 0, 0);
        do_reset();

        // ---- directed table -------------------------------------------------
        // Port 0 stream 0x0/0x4/0x8, immediate grants, responses one cycle later.
        vecs.push_back(mk(1, 32'h0,  0, 32'h0, 1, 0, 32'h0,    1, 32'h0,  1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 32'h4,  0, 32'h0, 1, 1, 32'hA0,   1, 32'h4,  1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 32'h8,  0, 32'h0, 1, 1, 32'hA1,   1, 32'h8,  1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 32'h8,  0, 32'h0, 0, 1, 32'hA2,   0, 32'h8,  0, 0, 1, 0, 1));
        // Lock: port 1 waits three cycles, then port 0 arrives.
        vecs.push_back(mk(0, 32'h40, 1, 32'h1000, 0, 0, 32'h0, 1, 32'h1000, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h40, 1, 32'h1000, 0, 0, 32'h0, 1, 32'h1000, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h40, 1, 32'h1000, 0, 0, 32'h0, 1, 32'h1000, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 32'h40, 1, 32'h1000, 0, 0, 32'h0, 1, 32'h1000, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 32'h40, 1, 32'h1000, 1, 0, 32'h0, 1, 32'h1000, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 32'h40, 0, 32'h1000, 1, 0, 32'h0, 1, 32'h40,   1, 0, 0, 0, 1));
        // Full FIFO (owners 1,0): no request, grant ignored, rvalid frees a slot.
        vecs.push_back(mk(1, 32'h44, 0, 32'h0, 0, 0, 32'h0,    0, 32'h44, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 32'h44, 0, 32'h0, 1, 0, 32'h0,    0, 32'h44, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 32'h44, 0, 32'h0, 1, 1, 32'hB1,   1, 32'h44, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 32'h0,  0, 32'h0, 0, 1, 32'hB2,   0, 32'h0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 32'h0, 0, 1, 32'hB3,   0, 32'h0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 32'h0, 0, 0, 32'h0,    0, 32'h0,  0, 0, 0, 0, 0));
        // Interleaved owners: port 0 then port 1, responses in grant order.
        vecs.push_back(mk(1, 32'h80, 0, 32'h0,    1, 0, 32'h0, 1, 32'h80,   1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h80, 1, 32'h2000, 1, 0, 32'h0, 1, 32'h2000, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 32'h0, 0, 1, 32'hC0,   0, 32'h0,  0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 32'h0, 0, 1, 32'hC1,   0, 32'h0,  0, 0, 0, 1, 1));
        // Stray rvalid with nothing outstanding, then idle: count must stay 0.
        vecs.push_back(mk(0, 32'h0,  0, 32'h0, 0, 1, 32'hD0,   0, 32'h0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,  0, 32'h0, 0, 0, 32'h0,    0, 32'h0,  0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].m0r, vecs[i].m0a, vecs[i].m1r, vecs[i].m1a,
                  vecs[i].gnt, vecs[i].rv, vecs[i].rd);
            #3;
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                      vecs[i].e_g0, vecs[i].e_g1, vecs[i].e_v0, vecs[i].e_v1,
                      vecs[i].e_busy);
            next_cycle();
        end

        // ---- conflict every cycle, immediate grants --------------------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            int ew;
            int pw;
            ew = conflict_winner(i);
            pw = conflict_winner(i - 1);
            if (i < 4) begin
                drive(1, 32'h100 + 32'(4 * i), 1, 32'h3000 + 32'(4 * i), 1, (i > 0), 32'hD00 + 32'(i));
                #3;
                check_all($sformatf("conf%0d", i), 1,
                          (ew == 1) ? 32'h3000 + 32'(4 * i) : 32'h100 + 32'(4 * i),
                          (ew == 0), (ew == 1), (i > 0) && (pw == 0), (i > 0) && (pw == 1), 1);
            end else begin
                drive(0, 0, 0, 0, 0, 1, 32'hD04);
                #3;
                check_all("conf4", 0, 32'h0, 0, 0, (pw == 0), (pw == 1), 1);
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        check_all("conf_idle", 0, 32'h0, 0, 0, 0, 0, 0);

        // ---- reset with two requests outstanding -----------------------------
        do_reset();
        drive(1, 32'h200, 0, 0, 1, 0, 0);
        #3;
        check_all("mrst_g0", 1, 32'h200, 1, 0, 0, 0, 1);
        next_cycle();
        drive(1, 32'h204, 0, 0, 1, 0, 0);
        #3;
        check_all("mrst_g1", 1, 32'h204, 1, 0, 0, 0, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 32'hE0);
        rst_n = 1'b0;
        #3;
        check_all("mrst_in_reset", 0, 32'h0, 0, 0, 0, 0, 0);
        next_cycle();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 32'hE1);
        #3;
        check_all("mrst_stray0", 0, 32'h0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 32'hE2);
        #3;
        check_all("mrst_stray1", 0, 32'h0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 32'h0, 1, 32'h300, 1, 0, 0);
        #3;
        check_all("mrst_new_g1", 1, 32'h300, 0, 1, 0, 0, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 1, 32'hE3);
        #3;
        check_all("mrst_new_rv1", 0, 32'h0, 0, 0, 0, 1, 1);
        next_cycle();

        // ---- randomized against the reference model --------------------------
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int   w;
            int   head;
            logic er;
            m0_req_i       = ($urandom_range(0, 3) != 0);
            m1_req_i       = ($urandom_range(0, 3) != 0);
            m0_addr_i      = $urandom;
            m1_addr_i      = $urandom;
            instr_gnt_i    = 1'($urandom_range(0, 1));
            instr_rvalid_i = (m_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            instr_rdata_i  = $urandom;
            #3;
            w    = model_winner();
            er   = ((w == 1) ? m1_req_i : m0_req_i) &&
                   ((m_q.size() < MAX_OUT) || instr_rvalid_i);
            head = (m_q.size() > 0) ? m_q[0] : -1;
            check_all($sformatf("rand%0d", i), er,
                      (w == 1) ? m1_addr_i : m0_addr_i,
                      er && instr_gnt_i && (w == 0), er && instr_gnt_i && (w == 1),
                      instr_rvalid_i && (head == 0), instr_rvalid_i && (head == 1),
                      (m_q.size() > 0) || er);
            if (instr_rvalid_i && m_q.size() > 0) void'(m_q.pop_front());
            if (er && instr_gnt_i) begin
                m_q.push_back(w);
                m_last = w;
            end
            if (m_lock < 0 && er && !instr_gnt_i) m_lock = w;
            else if (m_lock >= 0 && er && instr_gnt_i) m_lock = -1;
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
